// File: rtl/dmem_line_responder_pkg.sv
// Shared types for the dmem line responder: FSM state encoding, captured request, line size default.
package dmem_line_responder_pkg;

  localparam int DMEM_LINE_BYTES = 32;

  typedef enum logic [1:0] {
    dresp_idle_s,
    dresp_wb_s,
    dresp_fill_s,
    dresp_resp_s
  } dmem_resp_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        store;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_line_responder_line_buffer.sv
// One-line data store: full-line load, byte-enabled word write, combinational word read.
// A write in the same cycle as a load merges over the incoming line.
module dmem_line_buffer
  import dmem_line_responder_pkg::*;
#(
  parameter  int LINE_BYTES = DMEM_LINE_BYTES,
  localparam int LINE_W     = 8 * LINE_BYTES,
  localparam int NUM_WORDS  = LINE_BYTES / 4,
  localparam int IDX_W      = $clog2(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [LINE_W-1:0] load_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [3:0]        wr_mask,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_word,
  output logic [LINE_W-1:0] line
);

  logic [NUM_WORDS-1:0][31:0] words;

  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    logic [31:0] word_q;

    always_ff @(posedge clk) begin
      if (!rst) begin
        word_q <= '0;
      end else begin
        if (load_en) word_q <= load_data[w*32 +: 32];
        if (wr_en && idx == IDX_W'(w)) begin
          for (int b = 0; b < 4; b++)
            if (wr_mask[b]) word_q[b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end

    assign words[w] = word_q;
  end

  assign rd_word = words[idx];
  assign line    = words;

endmodule

// File: rtl/dmem_line_responder.sv
// Single-line dmem responder between LSQ and line-wide backing memory (hit / writeback / fill).
// DMEM_PERF_CNT_EN adds hit_count / miss_count ports.
module dmem_line_responder
  import dmem_line_responder_pkg::*;
#(
  parameter  int LINE_BYTES = DMEM_LINE_BYTES,
  localparam int LINE_W     = 8 * LINE_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dmem_addr,
  input  logic              dmem_rmask,
  input  logic [3:0]        dmem_wmask,
  input  logic [31:0]       dmem_wdata,
  output logic [31:0]       dmem_rdata,
  output logic              dmem_resp,
  output logic [31:0]       mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int OFF_W     = $clog2(LINE_BYTES);
  localparam int TAG_W     = 32 - OFF_W;
  localparam int NUM_WORDS = LINE_BYTES / 4;
  localparam int IDX_W     = OFF_W - 2;

  dmem_resp_state_t state;
  dmem_req_t        req_q;
  logic [TAG_W-1:0] buf_tag;
  logic             valid, dirty;

  logic             req_now, is_store, hit;
  logic             buf_load, buf_wr;
  logic [IDX_W-1:0] buf_idx;
  logic [3:0]       buf_mask;
  logic [31:0]      buf_wdata, buf_rd_word, fill_word;
  logic [NUM_WORDS-1:0][31:0] fill_words;
  logic [3:0]       unused_addr_lsb;

  assign is_store        = |dmem_wmask;
  assign req_now         = dmem_rmask | is_store;
  assign hit             = valid && (buf_tag == dmem_addr[31:OFF_W]);
  assign fill_words      = mem_rdata;
  assign fill_word       = fill_words[req_q.addr[OFF_W-1:2]];
  assign unused_addr_lsb = {dmem_addr[1:0], req_q.addr[1:0]};

  // Hit stores write from the live request; fill-time stores merge into the incoming line.
  always_comb begin
    buf_load  = 1'b0;
    buf_wr    = 1'b0;
    buf_idx   = dmem_addr[OFF_W-1:2];
    buf_mask  = dmem_wmask;
    buf_wdata = dmem_wdata;
    case (state)
      dresp_idle_s: buf_wr = req_now && hit && is_store;
      dresp_fill_s: begin
        buf_load  = mem_resp;
        buf_wr    = mem_resp && req_q.store;
        buf_idx   = req_q.addr[OFF_W-1:2];
        buf_mask  = req_q.wmask;
        buf_wdata = req_q.wdata;
      end
      default: ;
    endcase
  end

  dmem_line_buffer #(.LINE_BYTES(LINE_BYTES)) u_line_buffer (
    .clk       (clk),
    .rst       (rst),
    .load_en   (buf_load),
    .load_data (mem_rdata),
    .wr_en     (buf_wr),
    .idx       (buf_idx),
    .wr_mask   (buf_mask),
    .wr_data   (buf_wdata),
    .rd_word   (buf_rd_word),
    .line      (mem_wdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= dresp_idle_s;
      req_q      <= '0;
      buf_tag    <= '0;
      valid      <= 1'b0;
      dirty      <= 1'b0;
      dmem_rdata <= '0;
      dmem_resp  <= 1'b0;
      mem_addr   <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
    end else begin
      case (state)
        dresp_idle_s: begin
          if (req_now) begin
            req_q <= '{addr: dmem_addr, store: is_store, wmask: dmem_wmask, wdata: dmem_wdata};
            if (hit) begin
              state      <= dresp_resp_s;
              dmem_resp  <= 1'b1;
              dmem_rdata <= buf_rd_word;
              if (is_store) dirty <= 1'b1;
            end else if (dirty) begin
              state     <= dresp_wb_s;
              mem_write <= 1'b1;
              mem_addr  <= {buf_tag, {OFF_W{1'b0}}};
            end else begin
              state    <= dresp_fill_s;
              mem_read <= 1'b1;
              mem_addr <= {dmem_addr[31:OFF_W], {OFF_W{1'b0}}};
            end
          end
        end
        dresp_wb_s: begin
          if (mem_resp) begin
            state     <= dresp_fill_s;
            dirty     <= 1'b0;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            mem_addr  <= {req_q.addr[31:OFF_W], {OFF_W{1'b0}}};
          end
        end
        dresp_fill_s: begin
          if (mem_resp) begin
            state      <= dresp_resp_s;
            mem_read   <= 1'b0;
            mem_addr   <= '0;
            buf_tag    <= req_q.addr[31:OFF_W];
            valid      <= 1'b1;
            dirty      <= req_q.store;
            dmem_resp  <= 1'b1;
            dmem_rdata <= fill_word;
          end
        end
        dresp_resp_s: begin
          state     <= dresp_idle_s;
          dmem_resp <= 1'b0;
        end
        default: state <= dresp_idle_s;
      endcase
    end
  end

`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == dresp_idle_s && req_now) begin
      if (hit) hit_count  <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end
`endif

  // The initiator must hold its request while the line is being moved.
  always_ff @(posedge clk) begin
    if (rst && (state == dresp_wb_s || state == dresp_fill_s))
      assert (dmem_addr == req_q.addr && is_store == req_q.store);
    if (rst)
      assert (!(mem_read && mem_write));
  end

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder with a latency-modelled backing memory and a golden word store.
module tb_dmem_line_responder;

  localparam int LINE_BYTES = 32;
  localparam int LINE_W     = 8 * LINE_BYTES;
  localparam int NW         = LINE_BYTES / 4;
  localparam int MEM_LAT    = 3;
  localparam int MEM_CYC    = MEM_LAT + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       dmem_addr, dmem_wdata, dmem_rdata, mem_addr;
  logic              dmem_rmask, dmem_resp, mem_read, mem_write, mem_resp;
  logic [3:0]        dmem_wmask;
  logic [LINE_W-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0]       hit_count, miss_count;
`endif

  int checks = 0, failures = 0;
  int overlap_err = 0, stray_resp = 0;
  int exp_hits = 0, exp_misses = 0;
  bit in_op = 1'b0;

  typedef struct { bit wr; logic [31:0] addr; } mtx_t;
  mtx_t              mem_log[$];
  logic [31:0]       exp_q[$];
  logic [LINE_W-1:0] mem_model [int unsigned];
  logic [31:0]       gold [int unsigned];

  always #5 clk = ~clk;

  dmem_line_responder #(.LINE_BYTES(LINE_BYTES)) dut (
    .clk        (clk),
    .rst        (rst),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp)
`ifdef DMEM_PERF_CNT_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  function automatic logic [31:0] gword(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_word(a);
  endfunction

  function automatic logic [LINE_W-1:0] init_line(input logic [31:0] la);
    logic [LINE_W-1:0] l;
    for (int w = 0; w < NW; w++) l[w*32 +: 32] = init_word(la + 32'(4*w));
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] gold_line(input logic [31:0] la);
    logic [LINE_W-1:0] l;
    for (int w = 0; w < NW; w++) l[w*32 +: 32] = gword(la + 32'(4*w));
    return l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_line(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_tx(input string tag, input int i, input bit wr, input logic [31:0] a);
    chk({tag, "_kind"}, (i < mem_log.size()) ? 32'(mem_log[i].wr) : 32'hFFFF_FFFF, 32'(wr));
    chk({tag, "_addr"}, (i < mem_log.size()) ? mem_log[i].addr : 32'hFFFF_FFFF, a);
  endtask

  // Backing memory: answers each held request MEM_LAT+1 cycles after it appears.
  initial begin
    int lat;
    lat = 0;
    mem_resp = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_resp = 1'b0;
      if (rst && (mem_read || mem_write)) begin
        if (lat == MEM_LAT) begin
          lat = 0;
          mem_resp = 1'b1;
          if (mem_write) begin
            chk_line("wb_data", mem_wdata, gold_line(mem_addr));
            mem_model[mem_addr] = mem_wdata;
            mem_log.push_back('{1'b1, mem_addr});
          end else begin
            mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : init_line(mem_addr);
            mem_log.push_back('{1'b0, mem_addr});
          end
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) overlap_err++;
    if (dmem_resp && !in_op) stray_resp++;
  end

  task automatic dmem_op(input string tag, input logic [31:0] a, input logic rm,
                         input logic [3:0] wm, input logic [31:0] wd, input int exp_lat);
    int n;
    logic [31:0] pre, nw, got;
    pre = gword({a[31:2], 2'b00});
    exp_q.push_back(pre);
    if (wm != 4'b0) begin
      nw = pre;
      for (int b = 0; b < 4; b++) if (wm[b]) nw[b*8 +: 8] = wd[b*8 +: 8];
      gold[{a[31:2], 2'b00}] = nw;
    end
    if (exp_lat == 1) exp_hits++; else exp_misses++;
    in_op = 1'b1;
    dmem_addr = a; dmem_rmask = rm; dmem_wmask = wm; dmem_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dmem_resp && n < 200);
    chk({tag, "_latency"}, n, exp_lat);
    if (dmem_resp) begin
      got = exp_q.pop_front();
      chk({tag, "_rdata"}, dmem_rdata, got);
    end
    dmem_rmask = 1'b0; dmem_wmask = 4'b0;
    @(negedge clk);
    chk({tag, "_single_pulse"}, 32'(dmem_resp), 32'd0);
    in_op = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    dmem_addr = '0; dmem_rmask = 1'b0; dmem_wmask = 4'b0; dmem_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 32'({dmem_resp, mem_read, mem_write}), 32'd0);
    chk("rst_rdata", dmem_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk_line("rst_mem_wdata", mem_wdata, '0);
    rst = 1'b1;
    @(negedge clk);

    mem_log.delete();
    dmem_op("t1_cold_load", 32'h100, 1'b1, 4'b0, 32'h0, 1 + MEM_CYC);
    chk("t1_ntx", mem_log.size(), 32'd1);
    check_tx("t1_fill", 0, 1'b0, 32'h100);

    mem_log.delete();
    dmem_op("t2_hit_load", 32'h104, 1'b1, 4'b0, 32'h0, 1);
    chk("t2_ntx", mem_log.size(), 32'd0);

    mem_log.delete();
    dmem_op("t3_store", 32'h108, 1'b0, 4'b0011, 32'h0000ABCD, 1);
    dmem_op("t3_load", 32'h108, 1'b1, 4'b0, 32'h0, 1);
    chk("t3_ntx", mem_log.size(), 32'd0);

    mem_log.delete();
    dmem_op("t4_evict", 32'h200, 1'b1, 4'b0, 32'h0, 1 + 2*MEM_CYC);
    chk("t4_ntx", mem_log.size(), 32'd2);
    check_tx("t4_wb", 0, 1'b1, 32'h100);
    check_tx("t4_fill", 1, 1'b0, 32'h200);
`ifdef DMEM_PERF_CNT_EN
    chk("perf_hits", hit_count, exp_hits);
    chk("perf_misses", miss_count, exp_misses);
`endif

    mem_log.delete();
    dmem_addr = 32'h300; dmem_rmask = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_fill_active", 32'(mem_read), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_reset_abort", 32'({mem_read, mem_write, dmem_resp}), 32'd0);
    dmem_rmask = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    dmem_op("t5_reload", 32'h200, 1'b1, 4'b0, 32'h0, 1 + MEM_CYC);
    chk("t5_ntx", mem_log.size(), 32'd1);
    check_tx("t5_fill", 0, 1'b0, 32'h200);

    mem_log.delete();
    dmem_op("t6_rw_store", 32'h210, 1'b1, 4'b1111, 32'hCAFEF00D, 1);
    dmem_op("t6_evict", 32'h400, 1'b1, 4'b0, 32'h0, 1 + 2*MEM_CYC);
    check_tx("t6_wb", 0, 1'b1, 32'h200);
    check_tx("t6_fill", 1, 1'b0, 32'h400);
    dmem_op("t6_reread", 32'h210, 1'b1, 4'b0, 32'h0, 1 + MEM_CYC);

    chk("no_mem_overlap", overlap_err, 32'd0);
    chk("no_stray_resp", stray_resp, 32'd0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
